// File: rtl/instr_queue.sv
// Instruction FIFO between fetch and decode: {instr, pc_add4} entries, flush on redirect.
// Optional zero-latency empty-queue bypass enabled by defining INSTR_QUEUE_BYPASS_EN.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc_add4,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc_add4,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic head_vld;
    logic byp;
    logic push;
    logic pop;

    always_comb begin
        head_vld = (count_q != '0);
        in_ready = (count_q != FULL_CNT);
`ifdef INSTR_QUEUE_BYPASS_EN
        byp = ~head_vld & in_valid & ~flush;
`else
        byp = 1'b0;
`endif
        out_valid = head_vld | byp;
        if (byp) begin
            out_instr   = in_instr;
            out_pc_add4 = in_pc_add4;
        end else if (head_vld) begin
            out_instr   = mem_q[rd_ptr_q][63:32];
            out_pc_add4 = mem_q[rd_ptr_q][31:0];
        end else begin
            out_instr   = 32'h0;
            out_pc_add4 = 32'h0;
        end
        // A bypassed instruction that decode takes immediately never enters storage.
        push = in_valid & in_ready & ~flush & ~(byp & out_ready);
        pop  = head_vld & out_ready & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only: no reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {in_instr, in_pc_add4};
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: driver models occupancy, monitor checks dequeued data order.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc_add4;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc_add4;
    logic [AW:0]   count;

    instr_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc_add4  (in_pc_add4),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc_add4 (out_pc_add4),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          m_cnt    = 0;
    bit          known    = 1'b0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check observable state against the model, then advance the model.
    task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                        input bit orr, input bit fl, input bit rs);
        bit byp, push, pop;
        @(negedge clk);
        in_valid = iv; in_instr = ins; in_pc_add4 = pc;
        out_ready = orr; flush = fl; rst = rs;
        #1;
        byp = BYP && (m_cnt == 0) && iv && !fl;
        if (known) begin
            chk("count", 64'(count), 64'(m_cnt));
            chk("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
            chk("out_valid", 64'(out_valid), 64'((m_cnt != 0) || byp));
            if (m_cnt == 0 && !byp) chk("empty_nop", {out_instr, out_pc_add4}, 64'h0);
            if (byp) chk("bypass_data", {out_instr, out_pc_add4}, {ins, pc});
        end
        if (rs) begin
            m_cnt = 0;
            exp_q.delete();
            known = 1'b1;
        end else if (known) begin
            if (fl) begin
                m_cnt = 0;
                exp_q.delete();
            end else begin
                push = iv && (m_cnt != DEPTH);
                pop  = orr && (m_cnt != 0);
                if (byp && orr) push = 1'b0;
                if (push || (byp && orr)) exp_q.push_back({ins, pc});
                m_cnt = m_cnt + int'(push) - int'(pop);
            end
        end
    endtask

    // Monitor: every handshake on the output side must deliver the oldest outstanding entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (known && rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%h expected=none at %0t",
                             {out_instr, out_pc_add4}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_data", {out_instr, out_pc_add4}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc_add4 = '0;
        out_ready = 1'b0; flush = 1'b0;

        // Reset then idle
        step(0, 32'h0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, $urandom, $urandom, 1, 0, 0);

        // Fill, blocked fifth push, drain
        for (int i = 1; i <= 4; i++) step(1, 32'h20080000 + 32'(i), 32'(4 * i), 0, 0, 0);
        step(1, 32'h20080005, 32'h14, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, $urandom, $urandom, 1, 0, 0);

        // Streaming across pointer wrap
        for (int i = 0; i < 16; i++) step(1, 32'h30000000 + 32'(i), 32'h100 + 32'(4 * i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, $urandom, $urandom, 1, 0, 0);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) step(1, 32'h40000000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h4000DEAD, 32'h2FC, 1, 1, 0);
        step(1, 32'h08000010, 32'h14, 0, 0, 0);
        step(0, $urandom, $urandom, 1, 0, 0);
        step(0, $urandom, $urandom, 1, 0, 0);

        // Reset mid-operation
        step(1, 32'h50000001, 32'h304, 0, 0, 0);
        step(1, 32'h50000002, 32'h308, 0, 0, 0);
        step(0, $urandom, $urandom, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, $urandom, $urandom, 1, 0, 0);

        // Empty queue with simultaneous offer and accept
        step(1, 32'h1000FFFF, 32'h400, 1, 0, 0);
        step(0, $urandom, $urandom, 1, 0, 0);
        step(0, $urandom, $urandom, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);
        end

        for (int i = 0; i < DEPTH + 2; i++) step(0, $urandom, $urandom, 1, 0, 0);
        @(negedge clk);
        #3;
        chk("final_count", 64'(count), 64'h0);
        chk("final_scoreboard_left", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Small instruction FIFO between the fetch stage (produces instr, pc_add4) and decode.
- Decouples fetch from decode stalls.
- Flushes on redirect (taken branch/jump) so that wrong-path instructions are discarded.
- Buffers each {instr, pc_add4} pair with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  queue can accept this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc_add4  input  32  byte address of fetched instruction + 4.
- flush  input  1  discard all contents (redirect from Br/J resolution).
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_instr  output  32  head instruction word.
- out_pc_add4  output  32  head pc_add4.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit entries {instr, pc_add4}; wr_ptr, rd_ptr are AW bits wide and wrap modulo DEPTH; count is held in a separate register.
- Reset (rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0. Storage contents need not be cleared.
- Effect on outputs after reset: out_valid=0, in_ready=1, out_instr=0, out_pc_add4=0.
- in_ready = (count != DEPTH). It is combinational from count only; it does not depend on out_ready, so there is no pass-through when full.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- push: write entry at wr_ptr; wr_ptr+1 (wraps DEPTH-1 -> 0).
- pop: rd_ptr+1 (wraps).
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged and advances both pointers.
- out_valid = (count != 0).
- out_instr/out_pc_add4 = entry[rd_ptr] when count != 0, else 32'h0. An empty queue therefore presents a NOP.
- Latency: a push in cycle N is visible at the head in cycle N+1 at the earliest (queue empty before).
- Ordering: strict FIFO; no reordering or duplication.
- flush: at the next edge wr_ptr=rd_ptr=0, count=0.
  - A push or pop in the same cycle is ignored; no entry is consumed or written.
  - flush has priority over push/pop. rst has priority over flush.
- Full (count=DEPTH): in_ready=0; the fetch side must hold its data. A pop in that cycle frees one slot for the next cycle.
- Empty (count=0): out_ready is ignored; no pop occurs and the pointers are unchanged.
- Reset mid-operation: all contents are dropped exactly as by flush; no partially written entry survives.
- in_instr/in_pc_add4 are sampled only when push=1; they may be X otherwise.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, in_valid=1 and flush=0, the output is driven combinationally from the input: out_valid=1, out_instr=in_instr, out_pc_add4=in_pc_add4.
  - If out_ready=1 in that cycle, the instruction is consumed directly. It is not written, and the pointers and count are unchanged.
  - If out_ready=0, it is pushed normally.
  - in_ready is unchanged.
  - Result: zero-latency path when the queue is empty.
- Not defined: no bypass; the minimum latency is 1 cycle, as described under Behaviour.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> out_valid=0, in_ready=1, count=0, out_instr=0.
- Fill and drain: push instr 0x20080001..0x20080004 (pc_add4 0x4..0x10) with out_ready=0 -> count=4, in_ready=0. A 5th push while full is blocked. Then out_ready=1 for 4 cycles -> outputs appear in order 0x20080001..0x20080004, then count=0.
- Streaming: in_valid=1 and out_ready=1 continuously with incrementing instr values, run for 10 cycles past pointer wrap -> count stays 1, every value is seen exactly once in order.
- Flush with simultaneous push/pop: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The following push of 0x08000010 is the next head.
- Reset mid-operation: count=2, rst=1 for 1 cycle -> count=0, out_valid=0, and the old entries never reappear.
- Bypass check, with INSTR_QUEUE_BYPASS_EN defined: empty queue, in_valid=1, in_instr=0x1000FFFF, out_ready=1 -> out_instr=0x1000FFFF in the same cycle and count stays 0. Without the macro: out_valid=0 that cycle, out_instr=0x1000FFFF in the next cycle.
